eye_box_measure: RTL and testbench



---
 rtl/eye_pkg.sv | 20 ++
 rtl/roi_hit.sv | 21 ++
 rtl/eye_box_measure.sv | 163 ++++++++++++++++
 tb/tb_eye_box_measure.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/eye_pkg.sv
// Shared definitions for the eye bounding-box measurement slice:
// pixel/count widths, the min-coordinate sentinel and FSM state codes.
package eye_pkg;

   localparam int unsigned PIX_W = 11;
   localparam int unsigned CNT_W = 16;

   localparam logic [PIX_W-1:0] PIX_MAX = 11'd2047;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Inclusive extent of a non-empty coordinate range.
   function automatic logic [PIX_W-1:0] span(input logic [PIX_W-1:0] hi,
                                              input logic [PIX_W-1:0] lo);
      return hi - lo + 11'd1;
   endfunction

endpackage

// File: rtl/roi_hit.sv
// Combinational in-ROI test of a pixel position against inclusive bounds.
// Inverted bounds (x0>x1 or y0>y1) can never satisfy both comparisons,
// so such a ROI matches no pixel.
module roi_hit
   import eye_pkg::*;
(
   input  logic [PIX_W-1:0] xpos,
   input  logic [PIX_W-1:0] ypos,
   input  logic [PIX_W-1:0] x0,
   input  logic [PIX_W-1:0] x1,
   input  logic [PIX_W-1:0] y0,
   input  logic [PIX_W-1:0] y1,
   output logic             hit
);

   // Position lies inside both inclusive ranges.
   always_comb begin
      hit = (xpos >= x0) && (xpos <= x1) && (ypos >= y0) && (ypos <= y1);
   end

endmodule

// File: rtl/eye_box_measure.sv
// Bounding box of dark pixels inside a per-frame ROI, reported once per
// frame one cycle after the last active pixel.
// Optional macro EYE_BOX_MIN_PIX_EN: boxes with fewer than MIN_PIX dark
// pixels (but at least one) are treated as noise and leave the outputs held.
module eye_box_measure
   import eye_pkg::*;
#(
   parameter int unsigned H_DISP  = 800,
   parameter int unsigned V_DISP  = 480,
   parameter int unsigned MIN_PIX = 16
) (
   input  logic             module_clk,
   input  logic             module_rst,
   input  logic [PIX_W-1:0] lcd_pixel_xpos,
   input  logic [PIX_W-1:0] lcd_pixel_ypos,
   input  logic             pixel_en,
   input  logic             pixel_bin,
   input  logic [PIX_W-1:0] roi_x0,
   input  logic [PIX_W-1:0] roi_x1,
   input  logic [PIX_W-1:0] roi_y0,
   input  logic [PIX_W-1:0] roi_y1,
   output logic [PIX_W-1:0] eye_high,
   output logic [PIX_W-1:0] eye_wide,
   output logic             box_valid,
   output logic [CNT_W-1:0] dark_cnt
);

   localparam logic [PIX_W-1:0] X_LAST  = PIX_W'(H_DISP);
   localparam logic [PIX_W-1:0] Y_LAST  = PIX_W'(V_DISP);
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);
`ifdef EYE_BOX_MIN_PIX_EN
   localparam logic MIN_EN = 1'b1;
`else
   localparam logic MIN_EN = 1'b0;
`endif

   logic [1:0]       state;
   logic [PIX_W-1:0] sh_x0, sh_x1, sh_y0, sh_y1;
   logic [PIX_W-1:0] bx0, bx1, by0, by1;
   logic [PIX_W-1:0] xmin, xmax, ymin, ymax;
   logic [CNT_W-1:0] cnt;
   logic             fs, fe, hit, dark;
   logic             fs_take, acc_take, keep_prev;

   assign fs = pixel_en && (lcd_pixel_xpos == PIX_W'(1)) && (lcd_pixel_ypos == PIX_W'(1));
   assign fe = pixel_en && (lcd_pixel_xpos == X_LAST) && (lcd_pixel_ypos == Y_LAST);

   // A frame start is honoured in IDLE and ACCUM; ACCUM re-arms on a truncated frame.
   assign fs_take  = fs && ((state == ST_IDLE) || (state == ST_ACCUM));
   assign acc_take = dark && (state == ST_ACCUM) && !fs;
   assign keep_prev = MIN_EN && (cnt != '0) && (cnt < MIN_CNT);

   // The FS pixel is tested against the incoming ROI, since the shadow
   // registers only take those bounds on the same edge.
   always_comb begin
      bx0 = sh_x0;
      bx1 = sh_x1;
      by0 = sh_y0;
      by1 = sh_y1;
      if (fs) begin
         bx0 = roi_x0;
         bx1 = roi_x1;
         by0 = roi_y0;
         by1 = roi_y1;
      end
   end

   roi_hit u_roi_hit (
      .xpos (lcd_pixel_xpos),
      .ypos (lcd_pixel_ypos),
      .x0   (bx0),
      .x1   (bx1),
      .y0   (by0),
      .y1   (by1),
      .hit  (hit)
   );

   assign dark = pixel_en && pixel_bin && hit;

   // Frame sequencing: IDLE -> ACCUM on FS, ACCUM -> DONE on FE, DONE for one cycle.
   always_ff @(posedge module_clk or posedge module_rst) begin
      if (module_rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (fs) state <= ST_ACCUM;
            ST_ACCUM: if (!fs && fe) state <= ST_DONE;
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Shadow ROI bounds, captured at each accepted frame start.
   always_ff @(posedge module_clk or posedge module_rst) begin
      if (module_rst) begin
         sh_x0 <= '0;
         sh_x1 <= '0;
         sh_y0 <= '0;
         sh_y1 <= '0;
      end else if (fs_take) begin
         sh_x0 <= roi_x0;
         sh_x1 <= roi_x1;
         sh_y0 <= roi_y0;
         sh_y1 <= roi_y1;
      end
   end

   // Bounding-box and count accumulators; FS seeds them with its own pixel.
   always_ff @(posedge module_clk or posedge module_rst) begin
      if (module_rst) begin
         xmin <= PIX_MAX;
         ymin <= PIX_MAX;
         xmax <= '0;
         ymax <= '0;
         cnt  <= '0;
      end else if (fs_take) begin
         if (dark) begin
            xmin <= lcd_pixel_xpos;
            xmax <= lcd_pixel_xpos;
            ymin <= lcd_pixel_ypos;
            ymax <= lcd_pixel_ypos;
            cnt  <= CNT_W'(1);
         end else begin
            xmin <= PIX_MAX;
            ymin <= PIX_MAX;
            xmax <= '0;
            ymax <= '0;
            cnt  <= '0;
         end
      end else if (acc_take) begin
         if (lcd_pixel_xpos < xmin) xmin <= lcd_pixel_xpos;
         if (lcd_pixel_xpos > xmax) xmax <= lcd_pixel_xpos;
         if (lcd_pixel_ypos < ymin) ymin <= lcd_pixel_ypos;
         if (lcd_pixel_ypos > ymax) ymax <= lcd_pixel_ypos;
         if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end
   end

   // Result registers, loaded during the single DONE cycle.
   always_ff @(posedge module_clk or posedge module_rst) begin
      if (module_rst) begin
         eye_high  <= PIX_W'(1);
         eye_wide  <= '0;
         box_valid <= 1'b0;
         dark_cnt  <= '0;
      end else begin
         box_valid <= (state == ST_DONE);
         if (state == ST_DONE) begin
            if (cnt == '0) begin
               eye_wide <= '0;
               eye_high <= PIX_W'(1);
               dark_cnt <= '0;
            end else if (!keep_prev) begin
               eye_wide <= span(xmax, xmin);
               eye_high <= span(ymax, ymin);
               dark_cnt <= cnt;
            end
         end
      end
   end

endmodule

// File: tb/tb_eye_box_measure.sv
// Directed bench for eye_box_measure: table of whole-frame vectors plus
// hand-written sequences for truncated frames, ROI change and reset.
module tb_eye_box_measure;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] xpos = '0, ypos = '0;
   logic        en = 1'b0, bin = 1'b0;
   logic [10:0] rx0 = '0, rx1 = '0, ry0 = '0, ry1 = '0;
   logic [10:0] eye_high, eye_wide;
   logic        box_valid;
   logic [15:0] dark_cnt;

   int total = 0;
   int bad = 0;
   int pulses = 0;
   int prev_w = 0, prev_h = 1, prev_c = 0;

   always #5 clk = ~clk;

   eye_box_measure #(.H_DISP(800), .V_DISP(480), .MIN_PIX(16)) dut (
      .module_clk     (clk),
      .module_rst     (rst),
      .lcd_pixel_xpos (xpos),
      .lcd_pixel_ypos (ypos),
      .pixel_en       (en),
      .pixel_bin      (bin),
      .roi_x0         (rx0),
      .roi_x1         (rx1),
      .roi_y0         (ry0),
      .roi_y1         (ry1),
      .eye_high       (eye_high),
      .eye_wide       (eye_wide),
      .box_valid      (box_valid),
      .dark_cnt       (dark_cnt)
   );

   always @(posedge clk) if (box_valid === 1'b1) pulses++;

   typedef struct {
      int rx0, rx1, ry0, ry1;
      int dx0, dx1, dy0, dy1;
      int fsb, feb;
      int w, h, c;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pix(input int x, input int y, input int b);
      en = 1'b1;
      xpos = 11'(x);
      ypos = 11'(y);
      bin = (b != 0);
      @(posedge clk); #1;
      en = 1'b0;
      bin = 1'b0;
   endtask

   task automatic set_roi(input int a, input int b, input int c, input int d);
      rx0 = 11'(a); rx1 = 11'(b); ry0 = 11'(c); ry1 = 11'(d);
   endtask

   task automatic rect(input int x0, input int x1, input int y0, input int y1);
      for (int y = y0; y <= y1; y++) begin
         for (int x = x0; x <= x1; x++) pix(x, y, 1);
         idle(1);
      end
   endtask

   // Expected outputs after a completed frame, including noise suppression when enabled.
   task automatic expect_box(input string nm, input int w, input int h, input int c, input int p0);
      int ew, eh, ec;
      ew = w; eh = h; ec = c;
`ifdef EYE_BOX_MIN_PIX_EN
      if (c > 0 && c < 16) begin ew = prev_w; eh = prev_h; ec = prev_c; end
`endif
      prev_w = ew; prev_h = eh; prev_c = ec;
      chk({nm, " valid_at_fe"}, box_valid, 0);
      @(posedge clk); #1;
      chk({nm, " valid"}, box_valid, 1);
      chk({nm, " wide"}, eye_wide, ew);
      chk({nm, " high"}, eye_high, eh);
      chk({nm, " cnt"}, dark_cnt, ec);
      @(posedge clk); #1;
      chk({nm, " valid_drop"}, box_valid, 0);
      chk({nm, " pulses"}, pulses - p0, 1);
   endtask

   task automatic roi_frame(input int first);
      if (first != 0) set_roi(280, 360, 190, 230);
      pix(1, 1, 0);
      idle(2);
      rect(300, 339, 200, 209);
      pix(10, 240, 0);
      set_roi(280, 360, 245, 265);
      rect(300, 319, 250, 254);
      pix(800, 480, 0);
   endtask

   initial begin
      int p0;
      vt[0] = '{280, 360, 190, 230, 300, 339, 200, 209, 0, 0, 40, 10, 400};
      vt[1] = '{280, 360, 190, 230, 500, 509, 300, 301, 0, 0, 0, 1, 0};
      vt[2] = '{280, 360, 190, 230, 270, 299, 185, 195, 0, 0, 20, 6, 120};
      vt[3] = '{360, 280, 190, 230, 300, 339, 200, 209, 0, 0, 0, 1, 0};
      vt[4] = '{1, 800, 1, 480, 1, 0, 1, 0, 1, 1, 800, 480, 2};
      vt[5] = '{400, 400, 300, 300, 400, 400, 300, 300, 0, 0, 1, 1, 1};

      idle(2);
      chk("reset high", eye_high, 1);
      chk("reset wide", eye_wide, 0);
      chk("reset cnt", dark_cnt, 0);
      chk("reset valid", box_valid, 0);
      rst = 1'b0;
      idle(3);

      for (int i = 0; i < 6; i++) begin
         p0 = pulses;
         set_roi(vt[i].rx0, vt[i].rx1, vt[i].ry0, vt[i].ry1);
         pix(1, 1, vt[i].fsb);
         idle(2);
         rect(vt[i].dx0, vt[i].dx1, vt[i].dy0, vt[i].dy1);
         pix(10, 470, 0);
         pix(800, 480, vt[i].feb);
         expect_box($sformatf("vec%0d", i), vt[i].w, vt[i].h, vt[i].c, p0);
         idle(4);
      end

      // Truncated frame: the restart discards the first 100 dark pixels.
      p0 = pulses;
      set_roi(1, 800, 1, 480);
      pix(1, 1, 0);
      rect(10, 19, 10, 19);
      pix(5, 100, 0);
      pix(1, 1, 0);
      rect(50, 54, 60, 61);
      pix(800, 480, 0);
      expect_box("trunc", 5, 2, 10, p0);
      idle(4);

      // ROI change mid-frame applies from the next frame start.
      p0 = pulses;
      roi_frame(1);
      expect_box("roi_old", 40, 10, 400, p0);
      idle(4);
      p0 = pulses;
      roi_frame(0);
      expect_box("roi_new", 20, 5, 100, p0);
      idle(4);

      // Small box after a full one: reported, or held when noise suppression is on.
      p0 = pulses;
      set_roi(280, 360, 190, 230);
      pix(1, 1, 0);
      rect(300, 339, 200, 209);
      pix(800, 480, 0);
      expect_box("big", 40, 10, 400, p0);
      idle(4);
      p0 = pulses;
      pix(1, 1, 0);
      rect(300, 304, 200, 200);
      pix(800, 480, 0);
      expect_box("small", 5, 1, 5, p0);
      idle(4);

      // Reset mid-frame clears outputs at once; the rest of that frame is ignored.
      p0 = pulses;
      pix(1, 1, 0);
      rect(300, 309, 200, 201);
      pix(5, 300, 0);
      rst = 1'b1;
      #1;
      chk("rst high", eye_high, 1);
      chk("rst wide", eye_wide, 0);
      chk("rst cnt", dark_cnt, 0);
      chk("rst valid", box_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rect(300, 339, 310, 319);
      pix(800, 480, 0);
      idle(3);
      chk("rst no_pulse", pulses - p0, 0);
      chk("rst hold wide", eye_wide, 0);
      chk("rst hold high", eye_high, 1);
      prev_w = 0; prev_h = 1; prev_c = 0;
      p0 = pulses;
      pix(1, 1, 0);
      rect(300, 339, 200, 209);
      pix(800, 480, 0);
      expect_box("after_rst", 40, 10, 400, p0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
